// File: rtl/flop_mux_primitives.sv
// CR16 datapath primitives: enable/reset register, 4:1 and 16:1 N-bit muxes, plus a wrapper top.
// Define FLOP_POWERUP_INIT_EN to give flop_enable_reset a known power-up value of zero.

module flop_enable_reset #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
`ifdef FLOP_POWERUP_INIT_EN
  output logic [WIDTH-1:0] q = '0
`else
  output logic [WIDTH-1:0] q
`endif
);

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else if (enable)
      q <= d;
  end

endmodule

module mux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (select)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

module mux16 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d8,
  input  logic [WIDTH-1:0] d9,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic [WIDTH-1:0] d12,
  input  logic [WIDTH-1:0] d13,
  input  logic [WIDTH-1:0] d14,
  input  logic [WIDTH-1:0] d15,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (select)
      4'd0:  y = d0;
      4'd1:  y = d1;
      4'd2:  y = d2;
      4'd3:  y = d3;
      4'd4:  y = d4;
      4'd5:  y = d5;
      4'd6:  y = d6;
      4'd7:  y = d7;
      4'd8:  y = d8;
      4'd9:  y = d9;
      4'd10: y = d10;
      4'd11: y = d11;
      4'd12: y = d12;
      4'd13: y = d13;
      4'd14: y = d14;
      4'd15: y = d15;
    endcase
  end

endmodule

module flop_mux_primitives #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  input  logic [WIDTH-1:0]      m4_d0,
  input  logic [WIDTH-1:0]      m4_d1,
  input  logic [WIDTH-1:0]      m4_d2,
  input  logic [WIDTH-1:0]      m4_d3,
  input  logic [1:0]            m4_select,
  output logic [WIDTH-1:0]      m4_y,
  input  logic [15:0][WIDTH-1:0] m16_d,
  input  logic [3:0]            m16_select,
  output logic [WIDTH-1:0]      m16_y
);

  flop_enable_reset #(.WIDTH(WIDTH)) u_flop (
    .clock(clock), .reset(reset), .enable(enable), .d(d), .q(q)
  );

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .d0(m4_d0), .d1(m4_d1), .d2(m4_d2), .d3(m4_d3),
    .select(m4_select), .y(m4_y)
  );

  mux16 #(.WIDTH(WIDTH)) u_mux16 (
    .d0(m16_d[0]),   .d1(m16_d[1]),   .d2(m16_d[2]),   .d3(m16_d[3]),
    .d4(m16_d[4]),   .d5(m16_d[5]),   .d6(m16_d[6]),   .d7(m16_d[7]),
    .d8(m16_d[8]),   .d9(m16_d[9]),   .d10(m16_d[10]), .d11(m16_d[11]),
    .d12(m16_d[12]), .d13(m16_d[13]), .d14(m16_d[14]), .d15(m16_d[15]),
    .select(m16_select), .y(m16_y)
  );

endmodule

// File: tb/tb_flop_mux_primitives.sv
// Self-checking bench for flop_mux_primitives at WIDTH=16 using an expected-value queue.
module tb_flop_mux_primitives;

  localparam int unsigned W = 16;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic [W-1:0]         d;
  logic [W-1:0]         q;
  logic [W-1:0]         m4_d0, m4_d1, m4_d2, m4_d3;
  logic [1:0]           m4_select;
  logic [W-1:0]         m4_y;
  logic [15:0][W-1:0]   m16_d;
  logic [3:0]           m16_select;
  logic [W-1:0]         m16_y;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] expv;
  int checks = 0;
  int failures = 0;

  flop_mux_primitives #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .d(d), .q(q),
    .m4_d0(m4_d0), .m4_d1(m4_d1), .m4_d2(m4_d2), .m4_d3(m4_d3),
    .m4_select(m4_select), .m4_y(m4_y),
    .m16_d(m16_d), .m16_select(m16_select), .m16_y(m16_y)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive at the falling edge, then wait for the rising edge and sample 1 time unit later.
  task automatic flop_cycle(input logic r, input logic e, input logic [W-1:0] dv);
    @(negedge clock);
    reset = r;
    enable = e;
    d = dv;
    @(posedge clock);
    #1;
  endtask

  task automatic test_powerup;
`ifdef FLOP_POWERUP_INIT_EN
    checks++;
    if (q !== '0) begin
      failures++;
      $display("FAIL powerup q=%h expected=%h", q, 16'h0000);
    end
`endif
  endtask

  task automatic test_reset;
    exp_q.push_back(16'h0000);
    flop_cycle(1'b1, 1'b0, 16'h5555);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      failures++;
      $display("FAIL reset q=%h expected=%h", q, expv);
    end
  endtask

  task automatic test_load_hold;
    exp_q.push_back(16'hBEEF);
    flop_cycle(1'b0, 1'b1, 16'hBEEF);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      failures++;
      $display("FAIL load q=%h expected=%h", q, expv);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'hBEEF);
      flop_cycle(1'b0, 1'b0, 16'h1234);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        failures++;
        $display("FAIL hold%0d q=%h expected=%h", i, q, expv);
      end
    end
  endtask

  task automatic test_reset_priority;
    exp_q.push_back(16'h0000);
    flop_cycle(1'b1, 1'b1, 16'hFFFF);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      failures++;
      $display("FAIL reset_priority q=%h expected=%h", q, expv);
    end
    exp_q.push_back(16'hBEEF);
    flop_cycle(1'b0, 1'b1, 16'hBEEF);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      failures++;
      $display("FAIL resume_load q=%h expected=%h", q, expv);
    end
  endtask

  task automatic test_sync_reset;
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (q !== 16'hBEEF) begin
      failures++;
      $display("FAIL sync_reset_mid q=%h expected=%h", q, 16'hBEEF);
    end
    exp_q.push_back(16'hBEEF);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      failures++;
      $display("FAIL sync_reset_edge q=%h expected=%h", q, expv);
    end
  endtask

  task automatic test_mux4;
    logic [W-1:0] tbl[4];
    tbl[0] = 16'h0A0A; tbl[1] = 16'h1B1B; tbl[2] = 16'h2C2C; tbl[3] = 16'h3D3D;
    m4_d0 = tbl[0]; m4_d1 = tbl[1]; m4_d2 = tbl[2]; m4_d3 = tbl[3];
    for (int s = 0; s < 4; s++) begin
      m4_select = 2'(s);
      exp_q.push_back(tbl[s]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (m4_y !== expv) begin
        failures++;
        $display("FAIL mux4_sel%0d y=%h expected=%h", s, m4_y, expv);
      end
    end
  endtask

  task automatic test_mux16;
    for (int k = 0; k < 16; k++) m16_d[k] = 16'(32'h1000 + k);
    for (int s = 0; s < 16; s++) begin
      m16_select = 4'(s);
      exp_q.push_back(16'(32'h1000 + s));
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (m16_y !== expv) begin
        failures++;
        $display("FAIL mux16_sel%0d y=%h expected=%h", s, m16_y, expv);
      end
    end
  endtask

  task automatic test_unselected;
    int u;
    for (int s = 0; s < 16; s += 5) begin
      u = (s + 7) % 16;
      m16_select = 4'(s);
      m16_d[u] = 16'hFFFF;
      exp_q.push_back(16'(32'h1000 + s));
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (m16_y !== expv) begin
        failures++;
        $display("FAIL mux16_unsel%0d y=%h expected=%h", s, m16_y, expv);
      end
      m16_d[u] = 16'(32'h1000 + u);
    end
    m4_select = 2'd1;
    m4_d3 = 16'hFFFF;
    #1;
    checks++;
    if (m4_y !== 16'h1B1B) begin
      failures++;
      $display("FAIL mux4_unsel y=%h expected=%h", m4_y, 16'h1B1B);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; d = '0;
    m4_d0 = '0; m4_d1 = '0; m4_d2 = '0; m4_d3 = '0; m4_select = '0;
    m16_d = '0; m16_select = '0;
    test_powerup();
    test_reset();
    test_load_hold();
    test_reset_priority();
    test_sync_reset();
    test_mux4();
    test_mux16();
    test_unselected();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
